// File: rtl/jala_ctrl_pkg.sv
// Shared control/datapath definitions for the JALA stack CPU: opcodes, FSM states
// and the mux-select encodings the datapath decodes.
package jala_ctrl_pkg;

    localparam int STATE_W = 5;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_POPA  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_JPOP  = 4'h4;
    localparam logic [3:0] OP_BR    = 4'h5;
    localparam logic [3:0] OP_CALL  = 4'h6;
    localparam logic [3:0] OP_RET   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_LATCH    = 5'd2,
        S_DECODE   = 5'd3,
        S_POPA     = 5'd4,
        S_POP_RS   = 5'd5,
        S_LATA     = 5'd6,
        S_POPB     = 5'd7,
        S_LD_B     = 5'd8,
        S_LATB     = 5'd9,
        S_PUSH_RES = 5'd10,
        S_PUSH_B   = 5'd11,
        S_PUSH_IMM = 5'd12,
        S_PUSH_PC  = 5'd13,
        S_BRREL    = 5'd14,
        S_JMPA     = 5'd15,
        S_HALT     = 5'd16
    } state_t;

    // Port-1 address select (read data feeds IR/ValB)
    localparam logic [1:0] MD1_PC   = 2'b00;
    localparam logic [1:0] MD1_MSP  = 2'b01;
    localparam logic [1:0] MD1_VALA = 2'b10;

    // Port-2 address select (read data feeds ValA)
    localparam logic [1:0] MD2_MSP = 2'b00;
    localparam logic [1:0] MD2_RSP = 2'b01;

    localparam logic [2:0] MDATA_VALA = 3'b000;
    localparam logic [2:0] MDATA_VALB = 3'b001;
    localparam logic [2:0] MDATA_RES  = 3'b010;
    localparam logic [2:0] MDATA_SEXT = 3'b011;
    localparam logic [2:0] MDATA_ZEXT = 3'b100;
    localparam logic [2:0] MDATA_PC   = 3'b101;

    localparam logic PCSRC_INC  = 1'b0;
    localparam logic PCSRC_VALA = 1'b1;
    localparam logic PCADD_ONE  = 1'b0;
    localparam logic PCADD_SEXT = 1'b1;

    typedef struct packed {
        logic nop;
        logic pushi;
        logic popa;
        logic add;
        logic jpop;
        logic br;
        logic call;
        logic ret;
        logic load;
        logic halt;
    } opClass_t;

endpackage

// File: rtl/jala_op_decode.sv
// Combinational opcode classifier: maps the IR opcode field to a one-hot class
// vector and flags opcodes this revision does not define.
module jala_op_decode
    import jala_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opCode,
    output opClass_t       opClass,
    output logic           illegal
);

    always_comb begin
        opClass = '0;
        illegal = 1'b0;
        case (opCode)
            OPW'(OP_NOP):   opClass.nop   = 1'b1;
            OPW'(OP_PUSHI): opClass.pushi = 1'b1;
            OPW'(OP_POPA):  opClass.popa  = 1'b1;
            OPW'(OP_ADD):   opClass.add   = 1'b1;
            OPW'(OP_JPOP):  opClass.jpop  = 1'b1;
            OPW'(OP_BR):    opClass.br    = 1'b1;
            OPW'(OP_CALL):  opClass.call  = 1'b1;
            OPW'(OP_RET):   opClass.ret   = 1'b1;
            OPW'(OP_LOAD):  opClass.load  = 1'b1;
            OPW'(OP_HALT):  opClass.halt  = 1'b1;
            default:        illegal       = 1'b1;
        endcase
    end

endmodule

// File: rtl/jala_control_unit.sv
// Multi-cycle Moore control FSM for the JALA stack CPU; drives every datapath
// strobe and select from the state register, dispatching on the live IR opcode.
module jala_control_unit
    import jala_ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int STW = 5
) (
    input  logic           CLK,
    input  logic           Reset_n,
    input  logic [15:0]    IROut,
    output logic           PCWrite,
    output logic           PCSource,
    output logic           PCAdd,
    output logic           IRWrite,
    output logic           ValAWrite,
    output logic           ValBWrite,
    output logic           MemRead1,
    output logic           MemRead2,
    output logic           MemWrite1,
    output logic           MemWrite2,
    output logic [1:0]     MemDst1,
    output logic [1:0]     MemDst2,
    output logic [2:0]     MemData,
    output logic           MSPWrite,
    output logic           MSPPop,
    output logic           RSPWrite,
    output logic           RSPPop,
    output logic           Halted,
    output logic           Illegal,
    output logic [STW-1:0] State
);

    state_t   stateQ;
    state_t   stateD;
    opClass_t opClass;
    logic     illegalOp;
    logic     unusedOperand;

    // Operand bits belong to the datapath; only the opcode steers sequencing.
    assign unusedOperand = ^IROut[15-OPW:0];

    jala_op_decode #(.OPW(OPW)) u_op_decode (
        .opCode  (IROut[15:16-OPW]),
        .opClass (opClass),
        .illegal (illegalOp)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) stateQ <= S_IDLE;
        else          stateQ <= stateD;
    end

    assign State = STW'(stateQ);

    always_comb begin
        stateD    = stateQ;
        PCWrite   = 1'b0;
        PCSource  = PCSRC_INC;
        PCAdd     = PCADD_ONE;
        IRWrite   = 1'b0;
        ValAWrite = 1'b0;
        ValBWrite = 1'b0;
        MemRead1  = 1'b0;
        MemRead2  = 1'b0;
        MemWrite1 = 1'b0;
        MemWrite2 = 1'b0;
        MemDst1   = MD1_PC;
        MemDst2   = MD2_MSP;
        MemData   = MDATA_VALA;
        MSPWrite  = 1'b0;
        MSPPop    = 1'b0;
        RSPWrite  = 1'b0;
        RSPPop    = 1'b0;
        Halted    = 1'b0;
        Illegal   = 1'b0;

        case (stateQ)
            S_IDLE: stateD = S_FETCH;
            S_FETCH: begin
                MemRead1 = 1'b1;
                MemDst1  = MD1_PC;
                PCWrite  = 1'b1;
                PCAdd    = PCADD_ONE;
                PCSource = PCSRC_INC;
                stateD   = S_LATCH;
            end
            S_LATCH: begin
                IRWrite = 1'b1;
                stateD  = S_DECODE;
            end
            S_DECODE: begin
                Illegal = illegalOp;
                if (opClass.nop || illegalOp)                                     stateD = S_FETCH;
                else if (opClass.pushi)                                           stateD = S_PUSH_IMM;
                else if (opClass.popa || opClass.add || opClass.jpop || opClass.load) stateD = S_POPA;
                else if (opClass.br)                                              stateD = S_BRREL;
                else if (opClass.call)                                            stateD = S_PUSH_PC;
                else if (opClass.ret)                                             stateD = S_POP_RS;
                else if (opClass.halt)                                            stateD = S_HALT;
                else                                                              stateD = S_FETCH;
            end
            // Port-2 read and pointer pop share a cycle; the datapath addresses with the old SP.
            S_POPA: begin
                MemRead2 = 1'b1;
                MemDst2  = MD2_MSP;
                MSPWrite = 1'b1;
                MSPPop   = 1'b1;
                stateD   = S_LATA;
            end
            S_POP_RS: begin
                MemRead2 = 1'b1;
                MemDst2  = MD2_RSP;
                RSPWrite = 1'b1;
                RSPPop   = 1'b1;
                stateD   = S_LATA;
            end
            S_LATA: begin
                ValAWrite = 1'b1;
                if (opClass.add)                    stateD = S_POPB;
                else if (opClass.jpop || opClass.ret) stateD = S_JMPA;
                else if (opClass.load)              stateD = S_LD_B;
                else                                stateD = S_FETCH;
            end
            S_POPB: begin
                MemRead1 = 1'b1;
                MemDst1  = MD1_MSP;
                MSPWrite = 1'b1;
                MSPPop   = 1'b1;
                stateD   = S_LATB;
            end
            S_LD_B: begin
                MemRead1 = 1'b1;
                MemDst1  = MD1_VALA;
                stateD   = S_LATB;
            end
            S_LATB: begin
                ValBWrite = 1'b1;
                if (opClass.add)       stateD = S_PUSH_RES;
                else if (opClass.load) stateD = S_PUSH_B;
                else                   stateD = S_FETCH;
            end
            S_PUSH_RES, S_PUSH_B, S_PUSH_IMM: begin
                MemWrite2 = 1'b1;
                MemDst2   = MD2_MSP;
                MSPWrite  = 1'b1;
                MSPPop    = 1'b0;
                MemData   = (stateQ == S_PUSH_RES) ? MDATA_RES :
                            (stateQ == S_PUSH_B)   ? MDATA_VALB : MDATA_ZEXT;
                stateD    = S_FETCH;
            end
            // PC was already advanced in FETCH, so the saved return address is CALL+1.
            S_PUSH_PC: begin
                MemWrite2 = 1'b1;
                MemDst2   = MD2_RSP;
                MemData   = MDATA_PC;
                RSPWrite  = 1'b1;
                RSPPop    = 1'b0;
                stateD    = S_BRREL;
            end
            S_BRREL: begin
                PCWrite  = 1'b1;
                PCAdd    = PCADD_SEXT;
                PCSource = PCSRC_INC;
                stateD   = S_FETCH;
            end
            S_JMPA: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_VALA;
                stateD   = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
                stateD = S_HALT;
            end
            default: stateD = S_IDLE;
        endcase
    end

endmodule
